// File: rtl/tx_flow_ctrl.sv
// Link sequencer and strict-priority arbiter moving words main -> VC0/VC1 -> D0/D1.
// Pops are combinational, pushes follow one cycle later; a stage stalls while its target is almost-full.
module tx_flow_ctrl #(
    parameter int DATA_W = 6,
    parameter int TH_W   = 5,
    parameter int CNT_W  = 5
) (
    input  logic                clk,
    input  logic                RESET_L,
    input  logic                init,
    input  logic [5*TH_W-1:0]   thr_low,
    input  logic [5*TH_W-1:0]   thr_high,
    input  logic [4:0]          fifo_empty,
    input  logic [5*CNT_W-1:0]  fifo_count,
    input  logic [4:0]          fifo_error,
    input  logic [DATA_W-1:0]   main_data,
    input  logic [DATA_W-1:0]   vc0_data,
    input  logic [DATA_W-1:0]   vc1_data,
    output logic                pop_main,
    output logic                pop_vc0,
    output logic                pop_vc1,
    output logic                push_vc0,
    output logic                push_vc1,
    output logic [DATA_W-1:0]   vc_data_out,
    output logic                push_d0,
    output logic                push_d1,
    output logic [DATA_W-1:0]   d_data_out,
    output logic [5*TH_W-1:0]   thr_low_q,
    output logic [5*TH_W-1:0]   thr_high_q,
    output logic [4:0]          state,
    output logic                idle_out,
    output logic                active_out,
    output logic                error_out
);

    typedef enum logic [4:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } state_t;

    // Occupancy plus in-flight push needs one bit more than a count to avoid wrapping.
    localparam int AW = (CNT_W + 1 > TH_W) ? CNT_W + 1 : TH_W;

    function automatic logic f_af(input logic [CNT_W-1:0] cnt, input logic push,
                                  input logic [TH_W-1:0] thr);
        logic [AW-1:0] occ;
        occ = AW'(cnt) + AW'(push);
        return occ >= AW'(thr);
    endfunction

    state_t              r_state;
    logic                r_push_vc0, r_push_vc1, r_push_d0, r_push_d1;
    logic [DATA_W-1:0]   r_vc_data, r_d_data;
    logic [5*TH_W-1:0]   r_thr_low, r_thr_high;

    logic w_active, w_err, w_to_err, w_kill, w_any_push;
    logic w_af_vc0, w_af_vc1, w_af_d0, w_af_d1;
    logic w_main_af, w_vc0_af, w_vc1_af;
    logic w_unused_main_cnt;

    assign w_unused_main_cnt = ^fifo_count[CNT_W-1:0];

    assign w_af_vc0 = f_af(fifo_count[1*CNT_W +: CNT_W], r_push_vc0, r_thr_high[1*TH_W +: TH_W]);
    assign w_af_vc1 = f_af(fifo_count[2*CNT_W +: CNT_W], r_push_vc1, r_thr_high[2*TH_W +: TH_W]);
    assign w_af_d0  = f_af(fifo_count[3*CNT_W +: CNT_W], r_push_d0,  r_thr_high[3*TH_W +: TH_W]);
    assign w_af_d1  = f_af(fifo_count[4*CNT_W +: CNT_W], r_push_d1,  r_thr_high[4*TH_W +: TH_W]);

    assign w_main_af = main_data[DATA_W-1] ? w_af_vc1 : w_af_vc0;
    assign w_vc0_af  = vc0_data[DATA_W-2]  ? w_af_d1  : w_af_d0;
    assign w_vc1_af  = vc1_data[DATA_W-2]  ? w_af_d1  : w_af_d0;

    assign w_active = (r_state == ST_ACTIVE);
    assign pop_main = w_active & ~fifo_empty[0] & ~w_main_af;
    assign pop_vc0  = w_active & ~fifo_empty[1] & ~w_vc0_af;
    assign pop_vc1  = w_active & ~pop_vc0 & ~fifo_empty[2] & ~w_vc1_af;

    assign w_err      = |fifo_error;
    assign w_to_err   = w_err & ((r_state == ST_INIT) | (r_state == ST_IDLE) | w_active);
    // Words popped on the cycle the link faults are discarded rather than pushed.
    assign w_kill     = w_to_err | (r_state == ST_ERROR);
    assign w_any_push = r_push_vc0 | r_push_vc1 | r_push_d0 | r_push_d1;

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            r_state    <= ST_RESET;
            r_push_vc0 <= 1'b0;
            r_push_vc1 <= 1'b0;
            r_push_d0  <= 1'b0;
            r_push_d1  <= 1'b0;
            r_vc_data  <= '0;
            r_d_data   <= '0;
            r_thr_low  <= '0;
            r_thr_high <= '1;
        end else begin
            case (r_state)
                ST_RESET:  r_state <= ST_INIT;
                ST_INIT:   if (w_err) r_state <= ST_ERROR;
                           else if (!init) r_state <= ST_IDLE;
                ST_IDLE:   if (w_err) r_state <= ST_ERROR;
                           else if (init) r_state <= ST_INIT;
                           else if (!(&fifo_empty[2:0])) r_state <= ST_ACTIVE;
                ST_ACTIVE: if (w_err) r_state <= ST_ERROR;
                           else if (init) r_state <= ST_INIT;
                           else if ((&fifo_empty) && !w_any_push) r_state <= ST_IDLE;
                ST_ERROR:  r_state <= ST_ERROR;
                default:   r_state <= ST_ERROR;
            endcase

            if (r_state == ST_INIT) begin
                r_thr_low  <= thr_low;
                r_thr_high <= thr_high;
            end

            r_push_vc0 <= pop_main & ~main_data[DATA_W-1] & ~w_kill;
            r_push_vc1 <= pop_main &  main_data[DATA_W-1] & ~w_kill;
            r_push_d0  <= ((pop_vc0 & ~vc0_data[DATA_W-2]) | (pop_vc1 & ~vc1_data[DATA_W-2])) & ~w_kill;
            r_push_d1  <= ((pop_vc0 &  vc0_data[DATA_W-2]) | (pop_vc1 &  vc1_data[DATA_W-2])) & ~w_kill;

            if (pop_main)
                r_vc_data <= main_data;
            if (pop_vc0 | pop_vc1)
                r_d_data <= pop_vc0 ? vc0_data : vc1_data;
        end
    end

    assign push_vc0    = r_push_vc0;
    assign push_vc1    = r_push_vc1;
    assign push_d0     = r_push_d0;
    assign push_d1     = r_push_d1;
    assign vc_data_out = r_vc_data;
    assign d_data_out  = r_d_data;
    assign thr_low_q   = r_thr_low;
    assign thr_high_q  = r_thr_high;
    assign state       = r_state;
    assign idle_out    = (r_state == ST_IDLE);
    assign active_out  = w_active;
    assign error_out   = (r_state == ST_ERROR);

endmodule

// File: tb/tb_tx_flow_ctrl.sv
// Bench for tx_flow_ctrl: queue-backed FIFO environment, cycle-level reference model, directed scenarios.
module tb_tx_flow_ctrl;

    localparam int M_RESET = 0, M_INIT = 1, M_IDLE = 2, M_ACTIVE = 3, M_ERROR = 4;

    logic        clk = 1'b0;
    logic        RESET_L, init;
    logic [24:0] thr_low, thr_high, thr_low_q, thr_high_q;
    logic [4:0]  fifo_empty, fifo_error, state;
    logic [24:0] fifo_count;
    logic [5:0]  main_data, vc0_data, vc1_data, vc_data_out, d_data_out;
    logic        pop_main, pop_vc0, pop_vc1, push_vc0, push_vc1, push_d0, push_d1;
    logic        idle_out, active_out, error_out;

    always #5 clk = ~clk;

    tx_flow_ctrl #(.DATA_W(6), .TH_W(5), .CNT_W(5)) dut (
        .clk(clk), .RESET_L(RESET_L), .init(init),
        .thr_low(thr_low), .thr_high(thr_high),
        .fifo_empty(fifo_empty), .fifo_count(fifo_count), .fifo_error(fifo_error),
        .main_data(main_data), .vc0_data(vc0_data), .vc1_data(vc1_data),
        .pop_main(pop_main), .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
        .push_vc0(push_vc0), .push_vc1(push_vc1), .vc_data_out(vc_data_out),
        .push_d0(push_d0), .push_d1(push_d1), .d_data_out(d_data_out),
        .thr_low_q(thr_low_q), .thr_high_q(thr_high_q), .state(state),
        .idle_out(idle_out), .active_out(active_out), .error_out(error_out)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [5:0] qm[$], qv0[$], qv1[$], qd0[$], qd1[$];
    logic [4:0] err_force;

    int         m_state;
    logic       m_push[5];
    logic [5:0] m_vc_dat, m_d_dat;
    int         m_thl[5], m_thh[5];

    logic       c_pm, c_p0, c_p1, c_u0, c_u1, c_d0, c_d1;
    logic [5:0] c_vd, c_dd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        fifo_empty = {qd1.size() == 0, qd0.size() == 0, qv1.size() == 0, qv0.size() == 0, qm.size() == 0};
        fifo_count = {5'(qd1.size()), 5'(qd0.size()), 5'(qv1.size()), 5'(qv0.size()), 5'(qm.size())};
        main_data  = (qm.size()  > 0) ? qm[0]  : 6'h00;
        vc0_data   = (qv0.size() > 0) ? qv0[0] : 6'h00;
        vc1_data   = (qv1.size() > 0) ? qv1[0] : 6'h00;
        fifo_error = err_force;
    endtask

    function automatic int occ(input int i);
        return int'(fifo_count[i*5 +: 5]) + (m_push[i] ? 1 : 0);
    endfunction

    function automatic bit full(input int i);
        return occ(i) >= m_thh[i];
    endfunction

    // Reference model: checks the current cycle, then advances to the state after the next edge.
    task automatic at_neg();
        bit e_pm, e_p0, e_p1, err, anyp, kill;
        int ns;
        logic [24:0] e_thl, e_thh;
        @(negedge clk);
        e_pm = 0; e_p0 = 0; e_p1 = 0;
        if (!RESET_L) begin
            m_state = M_RESET;
            for (int i = 0; i < 5; i++) begin
                m_push[i] = 1'b0; m_thl[i] = 0; m_thh[i] = 31;
            end
            m_vc_dat = 6'h00; m_d_dat = 6'h00;
        end else if (m_state == M_ACTIVE) begin
            e_pm = !fifo_empty[0] && !full(main_data[5] ? 2 : 1);
            e_p0 = !fifo_empty[1] && !full(vc0_data[4] ? 4 : 3);
            e_p1 = !e_p0 && !fifo_empty[2] && !full(vc1_data[4] ? 4 : 3);
        end
        for (int i = 0; i < 5; i++) begin
            e_thl[i*5 +: 5] = 5'(m_thl[i]);
            e_thh[i*5 +: 5] = 5'(m_thh[i]);
        end
        chk("state", state, 32'(1) << m_state);
        chk("idle_out", idle_out, m_state == M_IDLE);
        chk("active_out", active_out, m_state == M_ACTIVE);
        chk("error_out", error_out, m_state == M_ERROR);
        chk("pop_main", pop_main, e_pm);
        chk("pop_vc0", pop_vc0, e_p0);
        chk("pop_vc1", pop_vc1, e_p1);
        chk("push_vc0", push_vc0, m_push[1]);
        chk("push_vc1", push_vc1, m_push[2]);
        chk("push_d0", push_d0, m_push[3]);
        chk("push_d1", push_d1, m_push[4]);
        if (!RESET_L || m_push[1] || m_push[2]) chk("vc_data_out", vc_data_out, m_vc_dat);
        if (!RESET_L || m_push[3] || m_push[4]) chk("d_data_out", d_data_out, m_d_dat);
        chk("thr_low_q", thr_low_q, e_thl);
        chk("thr_high_q", thr_high_q, e_thh);

        if (RESET_L) begin
            err  = |fifo_error;
            anyp = m_push[1] || m_push[2] || m_push[3] || m_push[4];
            case (m_state)
                M_RESET:  ns = M_INIT;
                M_INIT:   ns = err ? M_ERROR : (init ? M_INIT : M_IDLE);
                M_IDLE:   ns = err ? M_ERROR : init ? M_INIT : (fifo_empty[2:0] != 3'b111) ? M_ACTIVE : M_IDLE;
                M_ACTIVE: ns = err ? M_ERROR : init ? M_INIT : (fifo_empty == 5'h1F && !anyp) ? M_IDLE : M_ACTIVE;
                default:  ns = M_ERROR;
            endcase
            if (m_state == M_INIT)
                for (int i = 0; i < 5; i++) begin
                    m_thl[i] = int'(thr_low[i*5 +: 5]);
                    m_thh[i] = int'(thr_high[i*5 +: 5]);
                end
            kill = (ns == M_ERROR);
            m_push[1] = e_pm && !main_data[5] && !kill;
            m_push[2] = e_pm &&  main_data[5] && !kill;
            m_push[3] = ((e_p0 && !vc0_data[4]) || (e_p1 && !vc1_data[4])) && !kill;
            m_push[4] = ((e_p0 &&  vc0_data[4]) || (e_p1 &&  vc1_data[4])) && !kill;
            if (e_pm) m_vc_dat = main_data;
            if (e_p0) m_d_dat = vc0_data;
            else if (e_p1) m_d_dat = vc1_data;
            m_state = ns;
        end
        c_pm = pop_main; c_p0 = pop_vc0; c_p1 = pop_vc1;
        c_u0 = push_vc0; c_u1 = push_vc1; c_d0 = push_d0; c_d1 = push_d1;
        c_vd = vc_data_out; c_dd = d_data_out;
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
        if (c_pm && qm.size()  > 0) void'(qm.pop_front());
        if (c_p0 && qv0.size() > 0) void'(qv0.pop_front());
        if (c_p1 && qv1.size() > 0) void'(qv1.pop_front());
        if (c_u0) qv0.push_back(c_vd);
        if (c_u1) qv1.push_back(c_vd);
        if (c_d0) qd0.push_back(c_dd);
        if (c_d1) qd1.push_back(c_dd);
        refresh();
    endtask

    task automatic cyc(input int n);
        repeat (n) begin at_neg(); to_pos(); end
    endtask

    task automatic drain_d();
        qd0.delete(); qd1.delete(); refresh();
    endtask

    initial begin
        RESET_L = 1'b0; init = 1'b1; err_force = 5'h00;
        thr_low = {5{5'd1}}; thr_high = {5{5'd4}};
        m_state = M_RESET;
        refresh();
        cyc(2);
        chk("rst_thr_high", thr_high_q, 32'h1FFFFFF);
        chk("rst_thr_low", thr_low_q, 32'h0);

        // Bring-up: INIT latches thresholds, then IDLE
        RESET_L = 1'b1;
        cyc(2);
        chk("init_state", state, 5'b00010);
        chk("init_thr_high", thr_high_q, {5{5'd4}});
        init = 1'b0;
        cyc(1);
        chk("idle_state", state, 5'b00100);

        // Two main words through VC0 and VC1 into D0
        qm.push_back(6'h05); qm.push_back(6'h25); refresh();
        cyc(1);
        at_neg(); chk("t2_pop_main", pop_main, 1); to_pos();
        at_neg(); chk("t2_push_vc0", push_vc0, 1); chk("t2_vc_dat0", vc_data_out, 6'h05); to_pos();
        at_neg(); chk("t2_push_vc1", push_vc1, 1); chk("t2_vc_dat1", vc_data_out, 6'h25); to_pos();
        at_neg(); chk("t2_push_d0a", push_d0, 1); chk("t2_d_dat0", d_data_out, 6'h05); to_pos();
        at_neg(); chk("t2_push_d0b", push_d0, 1); chk("t2_d_dat1", d_data_out, 6'h25); to_pos();
        chk("t2_d0_size", qd0.size(), 2);
        if (qd0.size() == 2) begin
            chk("t2_d0_first", qd0[0], 6'h05);
            chk("t2_d0_second", qd0[1], 6'h25);
        end
        drain_d();
        cyc(2);
        chk("t2_back_idle", idle_out, 1);

        // Strict VC0 priority
        qv0.push_back(6'h01); qv0.push_back(6'h02); qv0.push_back(6'h03);
        qv1.push_back(6'h30); qv1.push_back(6'h31); refresh();
        cyc(1);
        for (int k = 0; k < 3; k++) begin
            at_neg(); chk("t3_vc0_wins", pop_vc0, 1); chk("t3_vc1_waits", pop_vc1, 0); to_pos();
        end
        at_neg(); chk("t3_vc1_turn", pop_vc1, 1); to_pos();
        cyc(3);
        chk("t3_d0_count", qd0.size(), 3);
        chk("t3_d1_count", qd1.size(), 2);
        drain_d();
        cyc(2);

        // D0 almost-full with push in flight blocks VC0 but not VC1
        qd0.push_back(6'h3F); qd0.push_back(6'h3F); qd0.push_back(6'h3F);
        qv0.push_back(6'h01); qv0.push_back(6'h02); qv1.push_back(6'h10); refresh();
        cyc(1);
        at_neg(); chk("t4_vc0_first", pop_vc0, 1); to_pos();
        at_neg(); chk("t4_inflight", push_d0, 1); chk("t4_vc0_held", pop_vc0, 0);
                  chk("t4_vc1_pops", pop_vc1, 1); to_pos();
        at_neg(); chk("t4_d1_push", push_d1, 1); chk("t4_d1_dat", d_data_out, 6'h10);
                  chk("t4_vc0_full", pop_vc0, 0); to_pos();
        drain_d();
        cyc(3);
        drain_d();
        cyc(2);
        chk("t4_back_idle", idle_out, 1);

        // init during ACTIVE with a push in flight
        qm.push_back(6'h07); qm.push_back(6'h27); refresh();
        cyc(1);
        at_neg(); chk("t6_pop1", pop_main, 1); to_pos();
        init = 1'b1; thr_high = {5{5'd6}}; refresh();
        at_neg(); chk("t6_push_vc0", push_vc0, 1); to_pos();
        at_neg(); chk("t6_init_state", state, 5'b00010); chk("t6_no_pop", pop_main, 0);
                  chk("t6_push_done", push_vc1, 1); chk("t6_push_dat", vc_data_out, 6'h27); to_pos();
        chk("t6_new_thr", thr_high_q, {5{5'd6}});
        init = 1'b0;
        cyc(9);
        drain_d();
        cyc(2);
        chk("t6_back_idle", idle_out, 1);

        // Sticky ERROR
        qm.push_back(6'h05); qm.push_back(6'h06); qm.push_back(6'h07); refresh();
        cyc(2);
        err_force = 5'b00100; refresh();
        at_neg(); chk("t5_pop_before", pop_main, 1); to_pos();
        at_neg(); chk("t5_err_state", state, 5'b10000); chk("t5_dropped", push_vc0, 0);
                  chk("t5_no_pop", pop_vc0, 0); to_pos();
        err_force = 5'b00000; init = 1'b1; refresh();
        cyc(3);
        init = 1'b0;
        cyc(2);
        chk("t5_sticky", error_out, 1);

        // Mid-traffic reset clears outputs immediately
        RESET_L = 1'b0;
        #1;
        chk("rst_err_clear", state, 5'b00001);
        cyc(2);
        RESET_L = 1'b1; init = 1'b1; thr_high = {5{5'd4}}; refresh();
        cyc(3);
        init = 1'b0;
        cyc(3);
        chk("rst_pre_push", push_vc0, 1);
        RESET_L = 1'b0;
        #1;
        chk("rst_now_state", state, 5'b00001);
        chk("rst_now_push_vc0", push_vc0, 0);
        chk("rst_now_push_d0", push_d0, 0);
        chk("rst_now_vc_dat", vc_data_out, 0);
        chk("rst_now_d_dat", d_data_out, 0);
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
